// File: rtl/pwl_phase_clk_gen_pkg.sv
// ---------------------------------------------------------------------------
// pwl_phase_clk_pkg
//   Shared widths, types and helpers for the PWL phase clock generator.
//   phase_t : one full clock cycle spans 2^PHASE_W LSB (signed offset word)
//   time_t  : time counter in clk cycles
//   slope_t : phase/cycle with FRAC_W fractional bits; the offset accumulator
//             uses the same format
//   bp_t    : one breakpoint {time, phase, slope to the next breakpoint}
// ---------------------------------------------------------------------------
package pwl_phase_clk_pkg;

    localparam int PHASE_W = 16;
    localparam int FRAC_W  = 8;
    localparam int TIME_W  = 16;
    localparam int NUM_BP  = 4;
    localparam int ACC_W   = PHASE_W + FRAC_W;
    localparam int IDX_W   = $clog2(NUM_BP);
    localparam int PTR_W   = $clog2(NUM_BP + 1);

    typedef logic signed [PHASE_W-1:0] phase_t;
    typedef logic        [TIME_W-1:0]  time_t;
    typedef logic signed [ACC_W-1:0]   slope_t;
    typedef logic        [IDX_W-1:0]   idx_t;
    typedef logic        [PTR_W-1:0]   ptr_t;

    typedef struct packed {
        time_t  t;
        phase_t p;
        slope_t s;
    } bp_t;

    // Integer phase -> accumulator format (exact, fraction zero).
    function automatic slope_t phase_to_acc(input phase_t p);
        return {p, {FRAC_W{1'b0}}};
    endfunction

    // Accumulator -> integer phase; dropping the fraction bits is a floor.
    function automatic phase_t acc_to_phase(input slope_t a);
        return a[ACC_W-1:FRAC_W];
    endfunction

endpackage

// File: rtl/pwl_phase_clk_gen_if.sv
// ---------------------------------------------------------------------------
// pwl_phase_clk_gen_if
//   Breakpoint configuration bus.
//   cfg_we    : write strobe (honoured only while the generator is idle)
//   cfg_idx   : breakpoint index
//   cfg_time  : breakpoint time T_i in clk cycles
//   cfg_phase : breakpoint phase P_i
//   cfg_slope : slope S_i for segment i -> i+1 (FRAC_W fractional bits)
//   master drives the bus, slave (the generator) receives it.
// ---------------------------------------------------------------------------
interface pwl_phase_clk_gen_if import pwl_phase_clk_pkg::*; ();

    logic   cfg_we;
    idx_t   cfg_idx;
    time_t  cfg_time;
    phase_t cfg_phase;
    slope_t cfg_slope;

    modport master (
        output cfg_we,
        output cfg_idx,
        output cfg_time,
        output cfg_phase,
        output cfg_slope
    );

    modport slave (
        input cfg_we,
        input cfg_idx,
        input cfg_time,
        input cfg_phase,
        input cfg_slope
    );

endinterface

// File: rtl/pwl_phase_clk_gen_nco_clk_core.sv
// ---------------------------------------------------------------------------
// nco_clk_core
//   Phase accumulator plus offset, turned into a square clock.
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   en        in  advance the NCO; 0 holds state and forces rise low
//   phase_off in  signed phase offset (positive = clock leads)
//   clk_out   out high while (nco + phase_off) is in the first half cycle
//   rise      out one-cycle pulse when clk_out goes 0 -> 1
// ---------------------------------------------------------------------------
module nco_clk_core import pwl_phase_clk_pkg::*; #(
    parameter int unsigned FCW = 4096
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  phase_t phase_off,
    output logic   clk_out,
    output logic   rise
);

    localparam logic [PHASE_W-1:0] FCW_INC = PHASE_W'(FCW);

    logic [PHASE_W-1:0] nco_p0;
    logic [PHASE_W-1:0] tot_p0;

    // Modulo-2^PHASE_W sum; the signed offset wraps naturally.
    assign tot_p0 = nco_p0 + phase_off;

    // ---- stage p0 -> p1: register clock level and edge pulse ----
    always_ff @(posedge clk) begin
        if (rst) begin
            nco_p0  <= '0;
            clk_out <= 1'b0;
            rise    <= 1'b0;
        end else if (en) begin
            nco_p0  <= nco_p0 + FCW_INC;
            clk_out <= ~tot_p0[PHASE_W-1];
            rise    <= ~tot_p0[PHASE_W-1] & ~clk_out;
        end else begin
            rise    <= 1'b0;
        end
    end

endmodule

// File: rtl/pwl_phase_clk_gen.sv
// ---------------------------------------------------------------------------
// pwl_phase_clk_gen
//   Stimulus clock with a programmable phase trajectory: either a DC offset
//   or an NUM_BP-breakpoint piecewise-linear profile over time, added to an
//   NCO to produce clk_out.
//   clk       in  system clock
//   rst       in  synchronous active-high reset (clears breakpoints too)
//   en        in  advance time, NCO and trajectory; 0 holds all state
//   mode      in  0 = DC (dc_phase), 1 = PWL breakpoint profile
//   dc_phase  in  signed offset used in DC mode
//   cfg       --  breakpoint write bus (slave side)
//   phase_off out current offset, floor of the accumulator
//   clk_out   out generated clock
//   rise      out one-cycle pulse on each clk_out rising transition
//   t_now     out time counter (saturating)
// ---------------------------------------------------------------------------
module pwl_phase_clk_gen import pwl_phase_clk_pkg::*; #(
    parameter int unsigned FCW = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  phase_t                    dc_phase,
    pwl_phase_clk_gen_if.slave        cfg,
    output phase_t                    phase_off,
    output logic                      clk_out,
    output logic                      rise,
    output time_t                     t_now
);

    localparam ptr_t PTR_END  = ptr_t'(NUM_BP);
    localparam ptr_t PTR_LAST = ptr_t'(NUM_BP - 1);

    bp_t    bp [NUM_BP];
    time_t  t_p0;
    ptr_t   ptr_p0;
    slope_t off_acc_p0;
    slope_t cur_slope_p0;

    bp_t    bp_cur;
    logic   bp_hit;

    // Breakpoint under the pointer and whether it is due this cycle. The
    // ptr < PTR_END guard keeps the exhausted pointer from ever firing.
    always_comb begin
        bp_cur = bp[ptr_p0[IDX_W-1:0]];
        bp_hit = (ptr_p0 < PTR_END) && (t_p0 >= bp_cur.t);
    end

    // ---- stage p0: time, breakpoint store and offset trajectory ----
    always_ff @(posedge clk) begin
        if (rst) begin
            t_p0         <= '0;
            ptr_p0       <= '0;
            off_acc_p0   <= '0;
            cur_slope_p0 <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp[i] <= '0;
            end
        end else begin
            if (cfg.cfg_we && !en) begin
                bp[cfg.cfg_idx] <= '{t: cfg.cfg_time, p: cfg.cfg_phase, s: cfg.cfg_slope};
            end
            if (en) begin
                if (t_p0 != '1) begin
                    t_p0 <= t_p0 + time_t'(1);
                end
                if (!mode) begin
                    off_acc_p0 <= phase_to_acc(dc_phase);
                end else if (bp_hit) begin
                    // Exact reload at every breakpoint: slope rounding error
                    // is discarded instead of carried into the next segment.
                    off_acc_p0   <= phase_to_acc(bp_cur.p);
                    cur_slope_p0 <= (ptr_p0 < PTR_LAST) ? bp_cur.s : '0;
                    ptr_p0       <= ptr_p0 + ptr_t'(1);
                end else if (ptr_p0 == '0) begin
                    off_acc_p0 <= phase_to_acc(bp[0].p);
                end else begin
                    off_acc_p0 <= off_acc_p0 + cur_slope_p0;
                end
            end
        end
    end

    assign t_now     = t_p0;
    assign phase_off = acc_to_phase(off_acc_p0);

    // ---- stage p1: NCO + offset -> clock ----
    nco_clk_core #(
        .FCW (FCW)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .phase_off (phase_off),
        .clk_out   (clk_out),
        .rise      (rise)
    );

endmodule

// File: tb/tb_pwl_phase_clk_gen.sv
// ---------------------------------------------------------------------------
// tb_pwl_phase_clk_gen
//   Two generators share clock, enable, reset and configuration: instance A
//   runs DC/PWL under test control, instance B stays in DC mode. Both are
//   compared each cycle against an arithmetic reference model, with extra
//   directed checks for the waveform shape, lead, sweep endpoints, freeze,
//   reset and ignored writes, then a randomized run.
// ---------------------------------------------------------------------------
module tb_pwl_phase_clk_gen;
    import pwl_phase_clk_pkg::*;

    localparam int unsigned FCW = 4096;
    localparam int PH_MOD = 1 << PHASE_W;
    localparam longint ACC_MOD = longint'(1) << ACC_W;

    logic   clk = 1'b0;
    logic   rst, en, mode;
    phase_t dc_a, dc_b;
    phase_t phase_off_a, phase_off_b;
    logic   clk_out_a, rise_a, clk_out_b, rise_b;
    time_t  t_now_a, t_now_b;

    int checks = 0;
    int errors = 0;

    pwl_phase_clk_gen_if cfg_if ();

    pwl_phase_clk_gen #(.FCW(FCW)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dc_phase(dc_a), .cfg(cfg_if),
        .phase_off(phase_off_a), .clk_out(clk_out_a), .rise(rise_a), .t_now(t_now_a)
    );

    pwl_phase_clk_gen #(.FCW(FCW)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(1'b0), .dc_phase(dc_b), .cfg(cfg_if),
        .phase_off(phase_off_b), .clk_out(clk_out_b), .rise(rise_b), .t_now(t_now_b)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int     m_t [2];
    int     m_ptr [2];
    int     m_nco [2];
    longint m_off [2];
    longint m_slope [2];
    bit     m_clk [2];
    bit     m_rise [2];
    int     mb_t [NUM_BP];
    int     mb_p [NUM_BP];
    longint mb_s [NUM_BP];

    function automatic longint wrap_acc(input longint x);
        longint r;
        r = x % ACC_MOD;
        if (r < 0) r += ACC_MOD;
        if (r >= ACC_MOD / 2) r -= ACC_MOD;
        return r;
    endfunction

    function automatic int phase_of(input longint off);
        return int'(off >>> FRAC_W);
    endfunction

    task automatic model_step(input int k, input bit r, input bit e, input bit md, input int dc);
        int tot;
        int t0;
        if (r) begin
            m_t[k] = 0; m_ptr[k] = 0; m_nco[k] = 0; m_off[k] = 0;
            m_slope[k] = 0; m_clk[k] = 0; m_rise[k] = 0;
        end else if (e) begin
            tot = ((m_nco[k] + phase_of(m_off[k])) % PH_MOD + PH_MOD) % PH_MOD;
            m_rise[k] = (tot < PH_MOD / 2) && !m_clk[k];
            m_clk[k]  = (tot < PH_MOD / 2);
            m_nco[k]  = (m_nco[k] + int'(FCW)) % PH_MOD;
            t0 = m_t[k];
            if (m_t[k] < (1 << TIME_W) - 1) m_t[k]++;
            if (!md) begin
                m_off[k] = longint'(dc) * (1 << FRAC_W);
            end else if (m_ptr[k] < NUM_BP && t0 >= mb_t[m_ptr[k]]) begin
                m_off[k]   = longint'(mb_p[m_ptr[k]]) * (1 << FRAC_W);
                m_slope[k] = (m_ptr[k] < NUM_BP - 1) ? mb_s[m_ptr[k]] : 0;
                m_ptr[k]++;
            end else if (m_ptr[k] == 0) begin
                m_off[k] = longint'(mb_p[0]) * (1 << FRAC_W);
            end else begin
                m_off[k] = wrap_acc(m_off[k] + m_slope[k]);
            end
        end else begin
            m_rise[k] = 0;
        end
    endtask

    task automatic model_cfg();
        if (rst) begin
            for (int i = 0; i < NUM_BP; i++) begin
                mb_t[i] = 0; mb_p[i] = 0; mb_s[i] = 0;
            end
        end else if (cfg_if.cfg_we && !en) begin
            mb_t[cfg_if.cfg_idx] = int'(cfg_if.cfg_time);
            mb_p[cfg_if.cfg_idx] = int'(cfg_if.cfg_phase);
            mb_s[cfg_if.cfg_idx] = longint'(cfg_if.cfg_slope);
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        check("A.phase_off", phase_off_a, phase_of(m_off[0]));
        check("A.clk_out",   clk_out_a,   m_clk[0]);
        check("A.rise",      rise_a,      m_rise[0]);
        check("A.t_now",     t_now_a,     m_t[0]);
        check("B.phase_off", phase_off_b, phase_of(m_off[1]));
        check("B.clk_out",   clk_out_b,   m_clk[1]);
        check("B.rise",      rise_b,      m_rise[1]);
        check("B.t_now",     t_now_b,     m_t[1]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0, rst, en, mode, int'(dc_a));
        model_step(1, rst, en, 1'b0, int'(dc_b));
        model_cfg();
        #1;
        compare_model();
    endtask

    task automatic write_bp(input int idx, input int tm, input int ph, input int sl);
        cfg_if.cfg_we    = 1'b1;
        cfg_if.cfg_idx   = idx_t'(idx);
        cfg_if.cfg_time  = time_t'(tm);
        cfg_if.cfg_phase = phase_t'(ph);
        cfg_if.cfg_slope = slope_t'(sl);
        cycle();
        cfg_if.cfg_we    = 1'b0;
    endtask

    task automatic program_sweep();
        write_bp(0, 100,  -13107, 5592);
        write_bp(1, 1300,  13107, 0);
        write_bp(2, 1300,  13107, 0);
        write_bp(3, 1300,  13107, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_t, exp_off;
        bit hit;

        rst = 1'b1; en = 1'b0; mode = 1'b0; dc_a = '0; dc_b = '0;
        cfg_if.cfg_we = 1'b0; cfg_if.cfg_idx = '0; cfg_if.cfg_time = '0;
        cfg_if.cfg_phase = '0; cfg_if.cfg_slope = '0;
        cycle();
        cycle();
        check("reset_phase_off", phase_off_a, 0);
        check("reset_clk_out",   clk_out_a,   0);
        check("reset_rise",      rise_a,      0);
        check("reset_t_now",     t_now_a,     0);
        rst = 1'b0;

        // DC waveform shape and quarter-cycle lead of B
        mode = 1'b0; dc_a = '0; dc_b = 16384; en = 1'b1;
        for (int i = 0; i < 48; i++) begin
            cycle();
            check("dc_clk_a",  clk_out_a, (i % 16) < 8);
            check("dc_rise_a", rise_a,    (i % 16) == 0);
            check("dc_off_b",  phase_off_b, 16384);
            if (i >= 4) begin
                check("dc_lead_clk_b",  clk_out_b, ((i + 4) % 16) < 8);
                check("dc_lead_rise_b", rise_b,    ((i + 4) % 16) == 0);
            end
        end

        // PWL sweep
        rst = 1'b1; en = 1'b0; cycle(); rst = 1'b0;
        program_sweep();
        mode = 1'b1; en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            cycle();
            if (t_now_a >= 1 && t_now_a <= 101) check("sweep_p0_hold", phase_off_a, -13107);
        end

        // freeze for 50 cycles
        exp_t = m_t[0]; exp_off = phase_of(m_off[0]);
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            check("freeze_t_now",     t_now_a,     exp_t);
            check("freeze_phase_off", phase_off_a, exp_off);
            check("freeze_rise",      rise_a,      0);
        end
        en = 1'b1;
        cycle();
        check("resume_t_now", t_now_a, exp_t + 1);

        hit = 1'b0;
        for (int i = 0; i < 900 && !hit; i++) begin
            // writes while running must be dropped
            cfg_if.cfg_we = (t_now_a >= 900 && t_now_a < 920);
            cfg_if.cfg_idx = 1; cfg_if.cfg_time = '0; cfg_if.cfg_phase = '0;
            cycle();
            if (t_now_a == 701)  check("sweep_mid", phase_off_a, -1);
            if (t_now_a >= 1301) check("sweep_end", phase_off_a, 13107);
            if (t_now_a == 1400) hit = 1'b1;
        end
        cfg_if.cfg_we = 1'b0;
        check("sweep_reached_1400", t_now_a, 1400);

        // reset mid-sweep
        rst = 1'b1; en = 1'b0; cycle(); rst = 1'b0;
        program_sweep();
        en = 1'b1;
        for (int i = 0; i < 300; i++) cycle();
        rst = 1'b1;
        cycle();
        check("rst_phase_off", phase_off_a, 0);
        check("rst_clk_out",   clk_out_a,   0);
        check("rst_rise",      rise_a,      0);
        check("rst_t_now",     t_now_a,     0);
        rst = 1'b0; en = 1'b0;
        program_sweep();
        en = 1'b1;
        cycle();
        check("restart_p0", phase_off_a, -13107);

        // randomized run
        rst = 1'b1; en = 1'b0; cycle(); rst = 1'b0;
        mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 199) == 0) mode = ~mode;
            if ($urandom_range(0, 99) == 0) dc_a = phase_t'($urandom);
            if ($urandom_range(0, 99) == 0) dc_b = phase_t'($urandom);
            cfg_if.cfg_we    = ($urandom_range(0, 3) == 0);
            cfg_if.cfg_idx   = idx_t'($urandom_range(0, NUM_BP - 1));
            cfg_if.cfg_time  = time_t'($urandom_range(0, 2500));
            cfg_if.cfg_phase = phase_t'($urandom);
            cfg_if.cfg_slope = slope_t'(int'($urandom_range(0, 1 << 17)) - (1 << 16));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwl_phase_clk_gen.md
Name: pwl_phase_clk_gen

Overview:
- Digital stimulus block for TDC/PLL characterisation.
- Produces a phase-offset trajectory, either a DC constant or an N-breakpoint piecewise-linear (PWL) profile over time.
- Converts the trajectory into a clock bit using an NCO: output phase = NCO phase + offset.
- Two instances (one DC, one PWL sweep) give a reference/feedback clock pair with a slowly varying phase difference.

Parameters:
- PHASE_W, 16: phase word width; 2^PHASE_W LSB = one full cycle (2π).
- FRAC_W, 8: fractional bits of the slope and offset accumulators.
- TIME_W, 16: width of the time counter, in clk cycles.
- NUM_BP, 4: number of PWL breakpoints.
- FCW, 4096: NCO frequency control word; output period = 2^PHASE_W/FCW clk cycles (default 16).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance time, NCO and trajectory; 0 = hold all state.
- mode  in  1  0 = DC, 1 = PWL.
- dc_phase  in  PHASE_W signed  offset used in DC mode.
- cfg_we  in  1  breakpoint write strobe.
- cfg_idx  in  $clog2(NUM_BP)  breakpoint index.
- cfg_time  in  TIME_W  breakpoint time T_i, in cycles.
- cfg_phase  in  PHASE_W signed  breakpoint phase P_i.
- cfg_slope  in  PHASE_W+FRAC_W signed  slope S_i, in LSB/cycle with FRAC_W fractional bits, for segment i→i+1.
- phase_off  out  PHASE_W signed  current offset, equal to off_acc >>> FRAC_W (floor).
- clk_out  out  1  generated clock.
- rise  out  1  one-cycle pulse on a 0→1 transition of clk_out.
- t_now  out  TIME_W  time counter.

Behaviour:
- Reset (synchronous, rst=1):
  - t, ptr, nco, off_acc, cur_slope, clk_out and rise go to 0.
  - All breakpoint registers clear to 0.
- Config:
  - When cfg_we=1 and en=0, breakpoint cfg_idx is written on the next edge.
  - Writes while en=1 are dropped.
  - Breakpoint times must be non-decreasing for a meaningful profile; the hardware behaviour below is defined for any contents.
- en=0: all state holds; rise=0.
- en=1, on each edge:
  - t increments and saturates at all-ones.
  - nco <= nco + FCW, modulo 2^PHASE_W.
- DC mode: off_acc <= dc_phase << FRAC_W.
- PWL mode, evaluated using the pre-increment t:
  - If ptr<NUM_BP and t >= T[ptr]:
    - off_acc <= P[ptr] << FRAC_W.
    - cur_slope <= S[ptr] if ptr<NUM_BP-1, else 0.
    - ptr++.
  - Else if ptr==0: off_acc <= P[0] << FRAC_W, so the offset holds P0 before T0.
  - Else: off_acc <= off_acc + cur_slope, with wrap-around arithmetic.
  - At most one breakpoint is consumed per cycle; equal times are applied on consecutive cycles.
  - After the last breakpoint the offset holds P[NUM_BP-1].
- Each breakpoint reload is exact, so slope rounding error never accumulates across segments.
- Mode switching mid-run does not reset ptr.
- Clock generation:
  - tot = nco + phase_off, modulo 2^PHASE_W.
  - clk_out <= ~tot[PHASE_W-1], i.e. high for phase in [0, 0.5) cycle.
  - rise <= ~tot[MSB] & ~clk_out.
  - Latency: 1 cycle from the registered nco/off_acc to clk_out.
  - A positive offset advances (leads) the clock.

Decomposition:
- Package pwl_phase_clk_pkg holds:
  - width constants;
  - typedefs phase_t, time_t, slope_t;
  - packed struct bp_t {time_t t; phase_t p; slope_t s;}.
- One sub-module, nco_clk_core, contains the NCO accumulator, phase summation, clk_out and rise logic.
- Trajectory, time counter and breakpoint storage live in the top module.

Test Plan:
- DC, dc_phase=0, FCW=4096, release rst, hold en=1:
  - clk_out = 1 for 8 cycles, then 0 for 8 cycles, period 16;
  - rise is asserted on cycle 1 after reset and every 16 cycles thereafter.
- DC with dc_phase=16384 (quarter cycle) vs 0 in a parallel instance:
  - clk_out leads by 4 cycles;
  - phase_off = 16384 constantly.
- PWL sweep: T0=100, P0=-13107, S0=5592; T1=1300, P1=13107:
  - phase_off = -13107 for t≤100;
  - phase_off = -1 at t≈700;
  - phase_off = 13107 exactly from t=1301 onward.
- en=0 for 50 cycles mid-sweep:
  - t_now, phase_off and clk_out frozen, rise=0;
  - trajectory resumes from the same point.
- rst asserted mid-sweep: next cycle all outputs are 0; the sweep restarts from P0 after rst is released.
- Config written during en=1 is ignored; duplicate breakpoint times are consumed on consecutive cycles.
